// File: rtl/collision_scan_sequencer_pkg.sv
// rtl/collision_scan_sequencer_pkg.sv - snake geometry constants, scan FSM states, overlap helper
package snake_pkg;

    localparam int SegWidth        = 10;
    localparam int SegHeight       = 10;
    localparam int BorderThickness = 10;
    localparam int DisplayWidth    = 240;
    localparam int DisplayHeight   = 320;
    localparam int AppleWidth      = 10;
    localparam int AppleHeight     = 10;
    localparam int MaxSegments     = 128;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        FINISH,
        GAMEOVER
    } scan_state_t;

    // Half-open rectangles; 10-bit sums cover the whole display plus one width.
    function automatic logic rect_overlap(
        input logic [9:0] ax, input logic [9:0] ay,
        input logic [9:0] aw, input logic [9:0] ah,
        input logic [9:0] bx, input logic [9:0] by,
        input logic [9:0] bw, input logic [9:0] bh
    );
        return (ax < bx + bw) && (bx < ax + aw) && (ay < by + bh) && (by < ay + ah);
    endfunction

endpackage

// File: rtl/collision_scan_sequencer_if.sv
// rtl/collision_scan_sequencer_if.sv - segment store read port shared by the scanner and the position memory
interface collision_scan_sequencer_if;

    logic [6:0] segAddr;
    logic [7:0] segX;
    logic [8:0] segY;

    modport master (output segAddr, input segX, input segY);
    modport slave  (input segAddr, output segX, output segY);

endinterface

// File: rtl/collision_scan_sequencer_tick_edge_sync.sv
// rtl/collision_scan_sequencer_tick_edge_sync.sv - two-flop synchroniser with rising-edge detect
module tick_edge_sync (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic rise
);

    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= async_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise = sync2 & ~prev;

endmodule

// File: rtl/collision_scan_sequencer.sv
// rtl/collision_scan_sequencer.sv - serial per-frame wall/apple/body collision scan over the segment store
module collision_scan_sequencer
    import snake_pkg::*;
#(
    parameter int SegWidth        = snake_pkg::SegWidth,
    parameter int SegHeight       = snake_pkg::SegHeight,
    parameter int BorderThickness = snake_pkg::BorderThickness,
    parameter int DisplayWidth    = snake_pkg::DisplayWidth,
    parameter int DisplayHeight   = snake_pkg::DisplayHeight,
    parameter int AppleWidth      = snake_pkg::AppleWidth,
    parameter int AppleHeight     = snake_pkg::AppleHeight,
    parameter int MaxSegments     = snake_pkg::MaxSegments
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       screenClock,
    input  logic [7:0] size,
    input  logic [7:0] appleLocX,
    input  logic [8:0] appleLocY,
    collision_scan_sequencer_if.master seg,
    output logic       busy,
    output logic       done,
    output logic       appleEaten,
    output logic       collision,
    output logic       scanOverrun
);

    localparam logic [9:0] SegW    = 10'(SegWidth);
    localparam logic [9:0] SegH    = 10'(SegHeight);
    localparam logic [9:0] AppleW  = 10'(AppleWidth);
    localparam logic [9:0] AppleH  = 10'(AppleHeight);
    localparam logic [9:0] Border  = 10'(BorderThickness);
    localparam logic [9:0] XLimit  = 10'(DisplayWidth - BorderThickness);
    localparam logic [9:0] YLimit  = 10'(DisplayHeight - BorderThickness);
    localparam logic [7:0] MaxSegs = 8'(MaxSegments);

    scan_state_t state;
    scan_state_t next_state;

    logic       tick;
    logic [7:0] n_clamp;
    logic [6:0] scan_last;
    logic [6:0] seg_addr;
    logic       issue;
    logic       rd_valid;
    logic [6:0] rd_idx;
    logic [9:0] head_x;
    logic [9:0] head_y;
    logic       wall_acc;
    logic       apple_acc;
    logic       body_acc;

    logic [9:0] seg_x10;
    logic [9:0] seg_y10;
    logic       is_head;
    logic       last_cmp;
    logic       wall_now;
    logic       apple_now;
    logic       body_now;

    tick_edge_sync u_tick (
        .clock    (clock),
        .reset    (reset),
        .async_in (screenClock),
        .rise     (tick)
    );

    always_comb begin
        n_clamp = size;
        if (size == 8'd0)
            n_clamp = 8'd1;
        else if (size > MaxSegs)
            n_clamp = MaxSegs;
    end

    assign seg_x10  = {2'b00, seg.segX};
    assign seg_y10  = {1'b0, seg.segY};
    assign is_head  = rd_valid && (rd_idx == 7'd0);
    assign last_cmp = rd_valid && (rd_idx == scan_last);

    assign wall_now  = is_head && ((seg_x10 < Border) || (seg_x10 + SegW > XLimit) ||
                                   (seg_y10 < Border) || (seg_y10 + SegH > YLimit));
    assign apple_now = is_head && rect_overlap(seg_x10, seg_y10, SegW, SegH,
                                               {2'b00, appleLocX}, {1'b0, appleLocY}, AppleW, AppleH);
    // Body compares use the head latched by index 0, one cycle earlier in the pipe.
    assign body_now  = rd_valid && (rd_idx != 7'd0) &&
                       rect_overlap(seg_x10, seg_y10, SegW, SegH, head_x, head_y, SegW, SegH);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (tick) next_state = SCAN;
            SCAN:     if (last_cmp) next_state = FINISH;
            FINISH:   next_state = collision ? GAMEOVER : IDLE;
            GAMEOVER: next_state = GAMEOVER;
            default:  next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scan_last   <= 7'd0;
            seg_addr    <= 7'd0;
            issue       <= 1'b0;
            rd_valid    <= 1'b0;
            rd_idx      <= 7'd0;
            head_x      <= 10'd0;
            head_y      <= 10'd0;
            wall_acc    <= 1'b0;
            apple_acc   <= 1'b0;
            body_acc    <= 1'b0;
            collision   <= 1'b0;
            scanOverrun <= 1'b0;
        end else begin
            rd_valid <= issue;
            rd_idx   <= seg_addr;

            if (state == IDLE && tick) begin
                scan_last <= 7'(n_clamp - 8'd1);
                seg_addr  <= 7'd0;
                issue     <= 1'b1;
                wall_acc  <= 1'b0;
                apple_acc <= 1'b0;
                body_acc  <= 1'b0;
            end else begin
                if (issue) begin
                    if (seg_addr == scan_last)
                        issue <= 1'b0;
                    else
                        seg_addr <= seg_addr + 7'd1;
                end
                if (state == FINISH || state == GAMEOVER)
                    seg_addr <= 7'd0;
                wall_acc  <= wall_acc  | wall_now;
                apple_acc <= apple_acc | apple_now;
                body_acc  <= body_acc  | body_now;
            end

            if (is_head) begin
                head_x <= seg_x10;
                head_y <= seg_y10;
            end

            if (last_cmp && (wall_acc || body_acc || wall_now || body_now))
                collision <= 1'b1;

            if (tick && (state == SCAN || state == FINISH))
                scanOverrun <= 1'b1;
        end
    end

    assign seg.segAddr = seg_addr;
    assign busy        = (state == SCAN);
    assign done        = (state == FINISH);
    assign appleEaten  = (state == FINISH) && apple_acc;

endmodule

// File: tb/tb_collision_scan_sequencer.sv
// tb/tb_collision_scan_sequencer.sv - directed bench for collision_scan_sequencer
module tb_collision_scan_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       screenClock;
    logic [7:0] size;
    logic [7:0] appleLocX;
    logic [8:0] appleLocY;
    logic       busy;
    logic       done;
    logic       appleEaten;
    logic       collision;
    logic       scanOverrun;

    logic [7:0] mem_x [128];
    logic [8:0] mem_y [128];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    collision_scan_sequencer_if seg_bus ();

    collision_scan_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .screenClock (screenClock),
        .size        (size),
        .appleLocX   (appleLocX),
        .appleLocY   (appleLocY),
        .seg         (seg_bus),
        .busy        (busy),
        .done        (done),
        .appleEaten  (appleEaten),
        .collision   (collision),
        .scanOverrun (scanOverrun)
    );

    always @(posedge clock) begin
        seg_bus.segX <= mem_x[seg_bus.segAddr];
        seg_bus.segY <= mem_y[seg_bus.segAddr];
    end

    task automatic fill_mem(input logic [7:0] hx, input logic [8:0] hy);
        for (int i = 0; i < 128; i++) begin
            mem_x[i] = 8'd20;
            mem_y[i] = 9'd20;
        end
        mem_x[0] = hx;
        mem_y[0] = hy;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        screenClock = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    // Returns at the falling edge inside cycle T (edge detected).
    task automatic start_edge();
        @(negedge clock);
        screenClock = 1'b1;
        repeat (2) @(negedge clock);
        screenClock = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        screenClock = 1'b0;
        size = 8'd1;
        appleLocX = 8'd200;
        appleLocY = 9'd20;
        fill_mem(8'd100, 9'd160);
        @(negedge clock);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (appleEaten !== 1'b0) begin errors++; $display("FAIL reset_apple got %b exp 0", appleEaten); end
        checks++; if (collision !== 1'b0) begin errors++; $display("FAIL reset_collision got %b exp 0", collision); end
        checks++; if (scanOverrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", scanOverrun); end
        checks++; if (seg_bus.segAddr !== 7'd0) begin errors++; $display("FAIL reset_segaddr got %0d exp 0", seg_bus.segAddr); end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_apple_hit();
        do_reset();
        fill_mem(8'd100, 9'd160);
        size = 8'd1;
        appleLocX = 8'd100;
        appleLocY = 9'd160;
        start_edge();
        for (int j = 1; j <= 4; j++) begin
            @(negedge clock);
            if (j == 1) begin
                checks++; if (seg_bus.segAddr !== 7'd0) begin errors++; $display("FAIL apple_segaddr got %0d exp 0", seg_bus.segAddr); end
            end
            checks++; if (busy !== (j <= 2)) begin errors++; $display("FAIL apple_busy T+%0d got %b exp %b", j, busy, j <= 2); end
            checks++; if (done !== (j == 3)) begin errors++; $display("FAIL apple_done T+%0d got %b exp %b", j, done, j == 3); end
            checks++; if (appleEaten !== (j == 3)) begin errors++; $display("FAIL apple_eaten T+%0d got %b exp %b", j, appleEaten, j == 3); end
            checks++; if (collision !== 1'b0) begin errors++; $display("FAIL apple_collision T+%0d got %b exp 0", j, collision); end
        end
    endtask

    task automatic test_walls();
        logic [7:0] hx [3];
        logic [8:0] hy [3];
        logic       ec [3];
        hx = '{8'd230, 8'd220, 8'd100};
        hy = '{9'd160, 9'd160, 9'd305};
        ec = '{1'b1, 1'b0, 1'b1};
        for (int v = 0; v < 3; v++) begin
            do_reset();
            fill_mem(hx[v], hy[v]);
            size = 8'd1;
            appleLocX = 8'd0;
            appleLocY = 9'd0;
            start_edge();
            repeat (2) @(negedge clock);
            checks++; if (collision !== 1'b0) begin errors++; $display("FAIL wall%0d_early got %b exp 0", v, collision); end
            @(negedge clock);
            checks++; if (done !== 1'b1) begin errors++; $display("FAIL wall%0d_done got %b exp 1", v, done); end
            checks++; if (collision !== ec[v]) begin errors++; $display("FAIL wall%0d_collision got %b exp %b", v, collision, ec[v]); end
            checks++; if (appleEaten !== 1'b0) begin errors++; $display("FAIL wall%0d_apple got %b exp 0", v, appleEaten); end
            repeat (3) @(negedge clock);
            checks++; if (collision !== ec[v]) begin errors++; $display("FAIL wall%0d_sticky got %b exp %b", v, collision, ec[v]); end
        end
    endtask

    task automatic test_body();
        do_reset();
        fill_mem(8'd100, 9'd160);
        mem_x[1] = 8'd110; mem_y[1] = 9'd160;
        mem_x[2] = 8'd120; mem_y[2] = 9'd160;
        mem_x[3] = 8'd100; mem_y[3] = 9'd165;
        size = 8'd4;
        appleLocX = 8'd200;
        appleLocY = 9'd20;
        start_edge();
        for (int j = 1; j <= 7; j++) begin
            @(negedge clock);
            if (j <= 4) begin
                checks++; if (seg_bus.segAddr !== 7'(j - 1)) begin errors++; $display("FAIL body_segaddr T+%0d got %0d exp %0d", j, seg_bus.segAddr, j - 1); end
            end
            checks++; if (busy !== (j <= 5)) begin errors++; $display("FAIL body_busy T+%0d got %b exp %b", j, busy, j <= 5); end
            checks++; if (done !== (j == 6)) begin errors++; $display("FAIL body_done T+%0d got %b exp %b", j, done, j == 6); end
            checks++; if (collision !== (j >= 6)) begin errors++; $display("FAIL body_collision T+%0d got %b exp %b", j, collision, j >= 6); end
        end
        start_edge();
        for (int j = 1; j <= 10; j++) begin
            @(negedge clock);
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gameover_busy T+%0d got %b exp 0", j, busy); end
        end
        checks++; if (scanOverrun !== 1'b0) begin errors++; $display("FAIL gameover_overrun got %b exp 0", scanOverrun); end
        checks++; if (collision !== 1'b1) begin errors++; $display("FAIL gameover_collision got %b exp 1", collision); end
    endtask

    task automatic test_overrun();
        int done_cnt;
        int done_at;
        done_cnt = 0;
        done_at = -1;
        do_reset();
        fill_mem(8'd100, 9'd160);
        size = 8'd100;
        appleLocX = 8'd200;
        appleLocY = 9'd20;
        start_edge();
        for (int j = 1; j <= 115; j++) begin
            @(negedge clock);
            if (done) begin done_cnt++; done_at = j; end
            if (j == 20) begin
                checks++; if (scanOverrun !== 1'b0) begin errors++; $display("FAIL overrun_early got %b exp 0", scanOverrun); end
            end
            if (j == 21) begin
                checks++; if (scanOverrun !== 1'b1) begin errors++; $display("FAIL overrun_set got %b exp 1", scanOverrun); end
            end
            if (j > 102) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL overrun_no_rescan T+%0d got %b exp 0", j, busy); end
            end
            if (j == 18) screenClock = 1'b1;
            if (j == 21) screenClock = 1'b0;
        end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL overrun_done_count got %0d exp 1", done_cnt); end
        checks++; if (done_at !== 102) begin errors++; $display("FAIL overrun_done_time got T+%0d exp T+102", done_at); end
        checks++; if (collision !== 1'b0) begin errors++; $display("FAIL overrun_collision got %b exp 0", collision); end
    endtask

    task automatic test_reset_mid_scan();
        int done_cnt;
        done_cnt = 0;
        do_reset();
        fill_mem(8'd100, 9'd160);
        size = 8'd50;
        appleLocX = 8'd200;
        appleLocY = 9'd20;
        start_edge();
        repeat (20) @(negedge clock);
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
        checks++; if (seg_bus.segAddr !== 7'd0) begin errors++; $display("FAIL abort_segaddr got %0d exp 0", seg_bus.segAddr); end
        checks++; if (done !== 1'b0 || appleEaten !== 1'b0 || collision !== 1'b0 || scanOverrun !== 1'b0)
            begin errors++; $display("FAIL abort_flags got %b%b%b%b exp 0000", done, appleEaten, collision, scanOverrun); end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int j = 0; j < 60; j++) begin
            @(negedge clock);
            if (done) done_cnt++;
        end
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL abort_no_done got %0d exp 0", done_cnt); end
        start_edge();
        for (int j = 1; j <= 53; j++) begin
            @(negedge clock);
            if (j <= 50) begin
                checks++; if (seg_bus.segAddr !== 7'(j - 1)) begin errors++; $display("FAIL rescan_segaddr T+%0d got %0d exp %0d", j, seg_bus.segAddr, j - 1); end
            end
            checks++; if (done !== (j == 52)) begin errors++; $display("FAIL rescan_done T+%0d got %b exp %b", j, done, j == 52); end
        end
    endtask

    task automatic test_size_bounds();
        int done_at;
        int done_cnt;
        logic [6:0] max_addr;
        do_reset();
        fill_mem(8'd100, 9'd160);
        size = 8'd0;
        appleLocX = 8'd200;
        appleLocY = 9'd20;
        start_edge();
        for (int j = 1; j <= 4; j++) begin
            @(negedge clock);
            if (j == 1) begin
                checks++; if (seg_bus.segAddr !== 7'd0) begin errors++; $display("FAIL size0_segaddr got %0d exp 0", seg_bus.segAddr); end
            end
            checks++; if (done !== (j == 3)) begin errors++; $display("FAIL size0_done T+%0d got %b exp %b", j, done, j == 3); end
        end
        done_at = -1;
        done_cnt = 0;
        max_addr = 7'd0;
        size = 8'd200;
        start_edge();
        for (int j = 1; j <= 134; j++) begin
            @(negedge clock);
            if (j == 5) size = 8'd3;
            if (seg_bus.segAddr > max_addr) max_addr = seg_bus.segAddr;
            if (done) begin done_cnt++; done_at = j; end
        end
        checks++; if (max_addr !== 7'd127) begin errors++; $display("FAIL size200_peak got %0d exp 127", max_addr); end
        checks++; if (done_at !== 130) begin errors++; $display("FAIL size200_done_time got T+%0d exp T+130", done_at); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL size200_done_count got %0d exp 1", done_cnt); end
        checks++; if (scanOverrun !== 1'b0) begin errors++; $display("FAIL size200_overrun got %b exp 0", scanOverrun); end
    endtask

    initial begin
        test_reset();
        test_apple_hit();
        test_walls();
        test_body();
        test_overrun();
        test_reset_mid_scan();
        test_size_bounds();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/collision_scan_sequencer.md
# collision_scan_sequencer

Sequences per-frame collision checking for the snake game. On each rising edge of the game refresh clock it walks the snake segment store through a single shared read port, one segment per cycle. It evaluates wall, apple and self-body hits against the head and reports `appleEaten` and `collision` to the game logic. It sits between the snake position memory and the game-state/score logic, replacing the 127-way parallel comparator array with a serial scan.

## Interface
- `SegWidth`, 10, snake segment width in pixels
- `SegHeight`, 10, snake segment height in pixels
- `BorderThickness`, 10, wall thickness in pixels
- `DisplayWidth`, 240, display width in pixels
- `DisplayHeight`, 320, display height in pixels
- `AppleWidth`, 10, apple width in pixels
- `AppleHeight`, 10, apple height in pixels
- `MaxSegments`, 128, depth of the segment store; index 0 is the head
- `clock`  in  1  50 MHz system clock; all logic on its rising edge
- `reset`  in  1  reset, asynchronous, active-high; clock `clock`
- `screenClock`  in  1  game refresh clock, asynchronous to `clock`
- `size`  in  8  live segment count, including the head
- `appleLocX`  in  8  apple X (top-left)
- `appleLocY`  in  9  apple Y (top-left)
- `segAddr`  out  7  segment store read address (registered)
- `segX`  in  8  segment X; valid one `clock` after `segAddr`
- `segY`  in  9  segment Y; valid one `clock` after `segAddr`
- `busy`  out  1  scan in progress
- `done`  out  1  one-cycle pulse at scan completion
- `appleEaten`  out  1  one-cycle pulse, coincident with `done`
- `collision`  out  1  sticky game-over flag
- `scanOverrun`  out  1  sticky flag: refresh edge arrived while `busy`

## Operation
- `screenClock` passes through a 2-flop synchroniser and a third flop. A rising edge is detected when sync=1 and prev=0. Cycle T is the cycle in which the edge is detected.
- Scan length: `n` = `size` snapshot taken at T. If `n` = 0, use 1. If `n` > `MaxSegments`, use `MaxSegments`. Later changes to `size` during the scan are ignored.
- FSM:
  - IDLE: on edge, go to SCAN.
  - SCAN: go to FINISH after the last compare.
  - FINISH (1 cycle): go to IDLE, or to GAMEOVER if `collision` is set.
  - GAMEOVER: absorbing until reset.
- SCAN issues addresses 0..n-1 on consecutive cycles. A one-stage valid pipe tags the returned data with its index.
- Index 0 (head):
  - Latch head X/Y into internal registers.
  - Wall hit if X < `BorderThickness`, or X+`SegWidth` > `DisplayWidth`-`BorderThickness`, or the same test on Y with the height parameters.
  - Apple hit if the rectangles overlap.
- Index k ≥ 1: body hit if the segment rectangle overlaps the latched head rectangle.
- Overlap of [a, a+Wa) and [b, b+Wb) is true iff a < b+Wb and b < a+Wa. All geometry arithmetic is 10-bit unsigned zero-extended; no 8/9-bit wrap.
- Hit flags accumulate during the scan and are cleared at scan start.
- In FINISH:
  - `done`=1.
  - `appleEaten`=1 if an apple hit occurred.
  - `collision` set if a wall or body hit occurred.
- An edge while `busy`, or in FINISH, is dropped and sets `scanOverrun`. Edges in GAMEOVER are ignored and do not set `scanOverrun`.
- Reset values: `segAddr`=0, `busy`=0, `done`=0, `appleEaten`=0, `collision`=0, `scanOverrun`=0, FSM=IDLE, synchroniser flops=0, head latch=0.
- Reset mid-scan aborts immediately. No `done` pulse is produced for the aborted scan.

## Timing
- `busy` rises at T+1 and falls at T+n+2.
- `segAddr` = k at T+1+k. It holds at n-1 through FINISH, then returns to 0 in IDLE.
- Compare for index k occurs at T+k+2. The last compare is at T+n+1.
- `done`, `appleEaten` and the `collision` set occur at T+n+2. `collision` stays high until reset.
- Latency from raw `screenClock` rise to `done` is 3..4 + n cycles (synchroniser uncertainty).
- Minimum `screenClock` period: n+3 `clock` cycles. A shorter period sets `scanOverrun`.

## Structure
- Shared package `snake_pkg` holds:
  - geometry constants (`SegWidth`, `SegHeight`, `BorderThickness`, `DisplayWidth`, `DisplayHeight`, `AppleWidth`, `AppleHeight`, `MaxSegments`);
  - the FSM state encoding (IDLE, SCAN, FINISH, GAMEOVER);
  - a `rect_overlap` function used for both apple and body tests.
- One sub-module: `tick_edge_sync` (2-flop synchroniser plus rising-edge detector, async reset to 0).

## Test plan
- Head (100,160), n=1, apple (100,160), edge at T → `segAddr`=0 at T+1; `done` and `appleEaten` pulse at T+3; `collision`=0; FSM returns to IDLE.
- Head (230,160) → `collision`=1 at T+3. Head (220,160), apple far → `collision`=0. Head (100,305) → `collision`=1.
- n=4; segments (100,160),(110,160),(120,160),(100,165) → `segAddr` 0..3 at T+1..T+4; `collision`=1 at T+6; later edges produce no `busy`.
- n=100, second `screenClock` edge at T+20 → `scanOverrun`=1; single `done` at T+102; no second scan starts.
- n=50, reset asserted at T+20 → all outputs 0 asynchronously; no `done`. The next edge after reset release runs a full scan from `segAddr`=0.
- `size`=0 → treated as n=1, `done` at T+3. `size`=200 → clamped, `segAddr` peaks at 127, `done` at T+130.
